// File: rtl/xalu_ise_mc.sv
// Multi-cycle CSIDH custom ALU: CADD/SUB in one cycle, MADLU/MADHU via digit-serial MAC.
// Optional macro XALU_ISE_BYPASS_EN lets a new request issue on the edge a result retires.
module xalu_ise_mc #(
   parameter int         XLEN  = 64,
   parameter int         MUL_W = 16,
   parameter logic [1:0] ISE_V = 2'b11
) (
   input  logic            ise_clk,
   input  logic            ise_rst,
   input  logic [5:0]      ise_fn,
   input  logic [6:0]      ise_imm,
   input  logic [XLEN-1:0] ise_in1,
   input  logic [XLEN-1:0] ise_in2,
   input  logic [XLEN-1:0] ise_in3,
   input  logic            ise_val,
   output logic            ise_rdy,
   output logic            ise_oval,
   input  logic            ise_ordy,
   output logic [XLEN-1:0] ise_out
);

   localparam int NDIG  = XLEN / MUL_W;
   localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int ACC_W = 2 * XLEN;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t                    state_q, state_d;
   logic [XLEN-1:0]           a_q, a_d;
   logic [XLEN-1:0]           b_q, b_d;
   logic                      hi_q, hi_d;
   logic [ACC_W-1:0]          acc_q, acc_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [XLEN-1:0]           res_q, res_d;

   logic                      op_ok;
   logic                      accept;
   logic                      is_mul;
   logic [XLEN+MUL_W-1:0]     prod;
   logic [ACC_W-1:0]          pp;
   logic [ACC_W-1:0]          acc_nxt;
   logic [31:0]               sh_amt;
   logic                      unused_ok;

   // Supported encodings 0001/0011/0101/0111 are exactly imm[3]=0, imm[0]=1.
   assign op_ok  = ISE_V[1] && (ise_fn[1:0] == 2'b00) && !ise_imm[3] && ise_imm[0];
   assign is_mul = !ise_imm[1];
   assign unused_ok = ^{ise_fn[5:2], ise_imm[6:4], ISE_V[0]};

`ifdef XALU_ISE_BYPASS_EN
   assign ise_rdy = ISE_V[1] && ((state_q == S_IDLE) || ((state_q == S_DONE) && ise_ordy));
`else
   assign ise_rdy = ISE_V[1] && (state_q == S_IDLE);
`endif

   assign accept   = ise_val && ise_rdy && op_ok;
   assign ise_oval = (state_q == S_DONE);
   assign ise_out  = ise_oval ? res_q : '0;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      res_d   = res_q;

      // b_q is shifted down each iteration, so the current digit is always its low slice.
      sh_amt  = 32'(cnt_q) * MUL_W;
      prod    = {{MUL_W{1'b0}}, a_q} * {{XLEN{1'b0}}, b_q[MUL_W-1:0]};
      pp      = ACC_W'(prod) << sh_amt;
      acc_nxt = acc_q + pp;

      case (state_q)
         S_BUSY: begin
            acc_d = acc_nxt;
            b_d   = b_q >> MUL_W;
            if (cnt_q == CNT_W'(NDIG - 1)) begin
               cnt_d   = '0;
               res_d   = hi_q ? acc_nxt[ACC_W-1:XLEN] : acc_nxt[XLEN-1:0];
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            if (ise_ordy) state_d = S_IDLE;
         end
         default: ;
      endcase

      // A launch may come from IDLE or, with bypass, from a retiring DONE; it overrides the above.
      if (accept) begin
         if (is_mul) begin
            a_d     = ise_in1;
            b_d     = ise_in2;
            hi_d    = ise_imm[2];
            acc_d   = {{XLEN{1'b0}}, ise_in3};
            cnt_d   = '0;
            state_d = S_BUSY;
         end else begin
            if (ise_imm[2])
               res_d = ise_in1 + (ise_in2 & {XLEN{ise_in3[0]}});
            else
               res_d = ise_in1 - ise_in2 - XLEN'(ise_in3[0]);
            state_d = S_DONE;
         end
      end
   end

   always_ff @(posedge ise_clk) begin
      if (ise_rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
      end
   end

   always_ff @(posedge ise_clk) begin
      a_q  <= a_d;
      b_q  <= b_d;
      hi_q <= hi_d;
   end

endmodule

// File: tb/tb_xalu_ise_mc.sv
// Directed self-checking bench for xalu_ise_mc at XLEN=64, MUL_W=16.
module tb_xalu_ise_mc;

   localparam int XLEN = 64;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [5:0]      fn  = '0;
   logic [6:0]      imm = '0;
   logic [XLEN-1:0] in1 = '0;
   logic [XLEN-1:0] in2 = '0;
   logic [XLEN-1:0] in3 = '0;
   logic            val = 1'b0;
   logic            rdy;
   logic            oval;
   logic            ordy = 1'b0;
   logic [XLEN-1:0] out;

   int n_cmp  = 0;
   int n_fail = 0;

   localparam logic [6:0] OP_CADD  = 7'b000_0111;
   localparam logic [6:0] OP_SUB   = 7'b000_0011;
   localparam logic [6:0] OP_MADLU = 7'b000_0001;
   localparam logic [6:0] OP_MADHU = 7'b000_0101;
   localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};

   always #5 clk = ~clk;

   xalu_ise_mc #(.XLEN(64), .MUL_W(16), .ISE_V(2'b11)) dut (
      .ise_clk(clk), .ise_rst(rst), .ise_fn(fn), .ise_imm(imm),
      .ise_in1(in1), .ise_in2(in2), .ise_in3(in3), .ise_val(val),
      .ise_rdy(rdy), .ise_oval(oval), .ise_ordy(ordy), .ise_out(out)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one edge, then scramble the operand buses.
   task automatic issue(input logic [6:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] c);
      fn = 6'b000000; imm = op; in1 = a; in2 = b; in3 = c; val = 1'b1;
      step();
      val = 1'b0;
      in1 = 64'hDEAD_BEEF_1234_5678; in2 = 64'h0BAD_F00D_CAFE_0001; in3 = 64'h5555;
   endtask

   // Latency counted in cycles starting from the accept edge.
   task automatic wait_oval(output int lat);
      lat = 1;
      while (!oval && lat < 30) begin
         step();
         lat++;
      end
   endtask

   task automatic retire();
      ordy = 1'b1;
      step();
      ordy = 1'b0;
   endtask

   task automatic run_op(input string name, input logic [6:0] op,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] c, input int exp_lat,
                         input logic [XLEN-1:0] exp_out);
      int lat;
      issue(op, a, b, c);
      wait_oval(lat);
      n_cmp++;
      if (lat !== exp_lat) begin
         n_fail++;
         $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
      end
      n_cmp++;
      if (out !== exp_out) begin
         n_fail++;
         $display("FAIL %s_out: got %h expected %h", name, out, exp_out);
      end
      retire();
      n_cmp++;
      if (oval !== 1'b0 || rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_retire: oval=%b rdy=%b expected oval=0 rdy=1", name, oval, rdy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      n_cmp++;
      if (rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b expected 1", rdy); end
      n_cmp++;
      if (oval !== 1'b0) begin n_fail++; $display("FAIL reset_oval: got %b expected 0", oval); end
      n_cmp++;
      if (out !== '0) begin n_fail++; $display("FAIL reset_out: got %h expected 0", out); end
   endtask

   task automatic test_mul();
      run_op("madlu", OP_MADLU, ONES, 64'd2, 64'd1, 5, ONES);
      run_op("madhu", OP_MADHU, ONES, 64'd2, 64'd1, 5, 64'd1);
      run_op("madhu_max", OP_MADHU, ONES, ONES, ONES, 5, ONES);
      run_op("madlu_max", OP_MADLU, ONES, ONES, ONES, 5, 64'd0);
      // 0x1_0000_0003 * 0x2_0000_0005 + 7 = 0x2_0000_000B_0000_0016
      run_op("madlu_mix", OP_MADLU, 64'h1_0000_0003, 64'h2_0000_0005, 64'd7, 5,
             64'h000B_0000_0016);
      run_op("madhu_mix", OP_MADHU, 64'h1_0000_0003, 64'h2_0000_0005, 64'd7, 5, 64'd2);
   endtask

   task automatic test_addsub();
      run_op("sub_borrow", OP_SUB, 64'd5, 64'd7, 64'd1, 1, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op("sub_plain", OP_SUB, 64'd100, 64'd30, 64'd0, 1, 64'd70);
      run_op("cadd_on", OP_CADD, 64'd10, 64'd3, 64'd1, 1, 64'd13);
      run_op("cadd_off", OP_CADD, 64'd10, 64'd3, 64'd0, 1, 64'd10);
      run_op("cadd_wrap", OP_CADD, ONES, 64'd2, 64'd3, 1, 64'd1);
   endtask

   task automatic test_backpressure();
      int lat;
      issue(OP_CADD, 64'd40, 64'd2, 64'd1);
      wait_oval(lat);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (oval !== 1'b1 || out !== 64'd42 || rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_hold%0d: oval=%b out=%h rdy=%b expected 1/2a/0",
                     i, oval, out, rdy);
         end
         step();
      end
      retire();
      n_cmp++;
      if (oval !== 1'b0 || out !== '0) begin
         n_fail++;
         $display("FAIL backpressure_retire: oval=%b out=%h expected 0/0", oval, out);
      end
   endtask

   task automatic test_unsupported();
      fn = 6'b000001; imm = OP_CADD; in1 = 64'd1; in2 = 64'd1; in3 = 64'd1; val = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_cmp++;
         if (oval !== 1'b0 || rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL unsup_fn%0d: oval=%b rdy=%b expected 0/1", i, oval, rdy);
         end
      end
      fn = 6'b000000; imm = 7'b000_0000;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if (oval !== 1'b0 || rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL unsup_imm%0d: oval=%b rdy=%b expected 0/1", i, oval, rdy);
         end
      end
      val = 1'b0;
   endtask

   task automatic test_reset_busy();
      int seen;
      issue(OP_MADLU, ONES, 64'd2, 64'd1);
      step(); step();
      n_cmp++;
      if (rdy !== 1'b0) begin n_fail++; $display("FAIL busy_rdy: got %b expected 0", rdy); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++;
      if (rdy !== 1'b1 || oval !== 1'b0 || out !== '0) begin
         n_fail++;
         $display("FAIL busy_reset: rdy=%b oval=%b out=%h expected 1/0/0", rdy, oval, out);
      end
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (oval) seen++;
      end
      n_cmp++;
      if (seen !== 0) begin n_fail++; $display("FAIL busy_late_oval: got %0d pulses expected 0", seen); end
   endtask

   task automatic test_back_to_back();
      ordy = 1'b1;
      fn = 6'b000000; imm = OP_CADD; in1 = 64'd10; in2 = 64'd3; in3 = 64'd1; val = 1'b1;
      step();
      n_cmp++;
      if (oval !== 1'b1 || out !== 64'd13) begin
         n_fail++;
         $display("FAIL b2b_first: oval=%b out=%h expected 1/d", oval, out);
      end
      in1 = 64'd20; in2 = 64'd5; in3 = 64'd1;
      step();
`ifdef XALU_ISE_BYPASS_EN
      val = 1'b0;
      n_cmp++;
      if (oval !== 1'b1 || out !== 64'd25) begin
         n_fail++;
         $display("FAIL b2b_second: oval=%b out=%h expected 1/19", oval, out);
      end
`else
      n_cmp++;
      if (oval !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_bubble: oval=%b expected 0", oval);
      end
      step();
      val = 1'b0;
      n_cmp++;
      if (oval !== 1'b1 || out !== 64'd25) begin
         n_fail++;
         $display("FAIL b2b_second: oval=%b out=%h expected 1/19", oval, out);
      end
`endif
      step();
      ordy = 1'b0;
      n_cmp++;
      if (oval !== 1'b0 || rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_drain: oval=%b rdy=%b expected 0/1", oval, rdy);
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_addsub();
      test_backpressure();
      test_unsupported();
      test_reset_busy();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
